// File: rtl/jam_cost_table.sv
// 8x8 cost matrix for the assignment engine: row-major valid/ready load, 1-cycle registered Cost lookup, result capture.
// ld_ready is high only while loading; ld_valid outside a load is dropped and flagged in ld_err.
module jam_cost_table #(
    parameter int COST_W = 7,
    parameter int IDX_W  = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [COST_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              table_ready,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    output logic [COST_W-1:0] Cost,
    input  logic              Valid,
    input  logic [9:0]        MinCost,
    input  logic [3:0]        MatchCount,
    output logic [9:0]        res_min,
    output logic [3:0]        res_match,
    output logic              res_done,
    output logic [3:0]        res_cnt,
    output logic [12:0]       checksum,
    output logic              ld_err
);
    localparam int PTR_W = 2 * IDX_W;
    localparam int DEPTH = 1 << PTR_W;

    typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [COST_W-1:0] mem [DEPTH];
    logic              accept;

    // ld_start takes priority, so a beat coinciding with it is dropped
    assign accept = ld_ready && ld_valid && !ld_start;

    always_ff @(posedge CLK) begin
        if (accept)
            mem[ptr] <= ld_data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= EMPTY;
            ptr         <= '0;
            ld_ready    <= 1'b0;
            table_ready <= 1'b0;
            checksum    <= '0;
            ld_err      <= 1'b0;
            res_min     <= '0;
            res_match   <= '0;
            res_done    <= 1'b0;
            res_cnt     <= '0;
        end else if (ld_start) begin
            state       <= LOAD;
            ptr         <= '0;
            ld_ready    <= 1'b1;
            table_ready <= 1'b0;
            checksum    <= '0;
            ld_err      <= 1'b0;
            res_done    <= 1'b0;
            res_cnt     <= '0;
        end else begin
            if (ld_valid && !ld_ready)
                ld_err <= 1'b1;

            case (state)
                LOAD: begin
                    if (accept) begin
                        checksum <= checksum + 13'(ld_data);
                        ptr      <= ptr + 1'b1;
                        if (ptr == PTR_W'(DEPTH - 1)) begin
                            state       <= READY;
                            ld_ready    <= 1'b0;
                            table_ready <= 1'b1;
                        end
                    end
                end
                READY:   ;
                default: ;
            endcase

            if (Valid && table_ready) begin
                res_min   <= MinCost;
                res_match <= MatchCount;
                res_done  <= 1'b1;
                if (res_cnt != 4'hF)
                    res_cnt <= res_cnt + 4'd1;
            end
        end
    end

    // Lookups read as zero until a complete matrix is present
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            Cost <= '0;
        else
            Cost <= table_ready ? mem[{W, J}] : '0;
    end
endmodule
